core_sequencer: RTL
===================

// Module: core_sequencer
// PURPOSE
//  Multi-cycle control FSM that sequences the RV32I-subset core datapath (PC, program memory, register file,
//  ALU, data memory) one instruction at a time. Replaces the single-cycle Control unit.
//  Drives all datapath enables and selects; waits on a data-memory ready handshake.
//  Counts retired instructions, halts on EBREAK/ECALL, timeout or illegal opcode.
// PARAMETERS
//  CNT_W         32  width of retired-instruction counter (wraps modulo 2^CNT_W)
//  MEM_TIMEOUT   16  max cycles in MEM waiting for mem_ready before fault (>=1)
// PORTS
//  clk                    in   1      clock, all state on rising edge
//  rst                    in   1      asynchronous, active-high reset
//  run                    in   1      level: 1 = keep executing, 0 = stop at next instruction boundary
//  opcode                 in   7      instr[6:0] of the current program-memory word
//  zero                   in   1      ALU zero flag (BEQ decision)
//  mem_ready              in   1      data memory has completed the current read/write
//  pc_write               out  1      PC register load enable
//  pc_src                 out  1      0 = PC+1, 1 = branch target
//  ir_write               out  1      instruction register load enable
//  reg_write_enable       out  1      register-file write strobe
//  data_mem_read_enable   out  1      data-memory read request
//  data_mem_write_enable  out  1      data-memory write request
//  mem_to_reg_sel         out  1      write-back mux: 0 = ALU, 1 = memory
//  alu_source_sel         out  1      ALU B mux: 0 = rs2, 1 = immediate
//  alu_op                 out  2      to ALUControl: 00 add, 01 sub (branch), 10 funct-decoded
//  state_o                out  3      current FSM state (debug)
//  halted                 out  1      sticky, FSM in HALT
//  fault                  out  1      sticky, halt caused by illegal opcode or memory timeout
//  retired                out  CNT_W  instructions retired since reset
// BEHAVIOUR
//  Reset: state=IDLE; every output 0; retired=0; class/wait registers 0. Reset mid-instruction aborts immediately,
//   enables drop asynchronously with rst, no partial retire.
//  States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. Registered state. Outputs combinational from state and latched class only.
//  IDLE: run=1 -> FETCH; else stay.  FETCH: ir_write=1 -> DECODE.
//  DECODE: latch class from opcode: 0110011 R, 0010011 I, 0000011 LOAD, 0100011 STORE, 1100011 BEQ,
//   1110011 SYS -> HALT (fault=0); any other -> HALT (fault=1). opcode ignored outside DECODE.
//  EXEC: R: alu_op=10,src=0 -> WB.  I: alu_op=10,src=1 -> WB.  LOAD/STORE: alu_op=00,src=1 -> MEM.
//   BEQ: alu_op=01,src=0; pc_write=1, pc_src=zero; retire.
//  MEM: alu_op=00,src=1 held; LOAD holds data_mem_read_enable, STORE holds data_mem_write_enable until mem_ready.
//   mem_ready in first MEM cycle = zero-wait. LOAD+ready -> WB. STORE+ready: pc_write=1, pc_src=0; retire.
//   Wait counter reset on MEM entry; MEM_TIMEOUT cycles without ready -> HALT, fault=1, enables drop.
//   mem_ready outside MEM ignored.
//  WB: reg_write_enable=1 one cycle; mem_to_reg_sel=1 for LOAD else 0; pc_write=1, pc_src=0; retire.
//  Retire: retired+=1 same edge as pc_write. Next state FETCH if run=1 else IDLE.
//   run sampled only at retire and in IDLE; a deasserted run never aborts an instruction.
//  Latency (cycles FETCH..retire): BEQ 3, R/I 4, STORE 4+waits, LOAD 5+waits.
//  HALT: all enables 0, halted=1, sticky until rst; run ignored. retired wraps at 2^CNT_W silently.
//  At most one of pc_write/reg_write_enable/mem enables changes meaning per state. read and write enables never both 1.
// STRUCTURE
//  core_pkg: opcode localparams, ALU_OP_ADD/SUB/FUNCT constants, state_t and instr_class_t enums.
//  Sub-module core_opcode_decode (combinational opcode -> instr_class_t, illegal flag). FSM, counters in core_sequencer.
// TESTING
//  rst, run=1, opcode=0110011 -> FETCH/DECODE/EXEC/WB; reg_write_enable=1 only in cycle 4; retired=1; back to FETCH.
//  LOAD, mem_ready low 3 cycles then high -> read_enable high 4 cycles; WB mem_to_reg_sel=1; total 8 cycles.
//  STORE, MEM_TIMEOUT=4, mem_ready never -> HALT after 4 MEM cycles; fault=1; retired unchanged.
//  BEQ with zero=1 then zero=0 -> pc_write=1, pc_src=1 then 0 in EXEC; 3 cycles each; retired+=2.
//  opcode=0000000 -> HALT fault=1. opcode=1110011 -> HALT fault=0. run toggled afterward -> no state change.
//  rst pulsed mid-MEM -> outputs 0 immediately; IDLE; retired=0. run=0 during R-type -> completes, then IDLE.

Source files
------------

// File: rtl/core_pkg.sv
// Shared opcodes, ALU op codes and enums for the multi-cycle core sequencer.
package core_pkg;

  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned ALU_OP_W = 2;
  localparam int unsigned STATE_W  = 3;

  localparam logic [OPCODE_W-1:0] OPC_R     = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OPC_I     = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OPC_LOAD  = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OPC_STORE = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OPC_BEQ   = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OPC_SYS   = 7'b1110011;

  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [ALU_OP_W-1:0] ALU_OP_FUNCT = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE  = 3'd0,
    CLS_R     = 3'd1,
    CLS_I     = 3'd2,
    CLS_LOAD  = 3'd3,
    CLS_STORE = 3'd4,
    CLS_BEQ   = 3'd5,
    CLS_SYS   = 3'd6
  } instr_class_t;

endpackage

// File: rtl/core_sequencer_if.sv
// Control bundle between the sequencer (master) and the core datapath (slave).
interface core_sequencer_if #(
  parameter int unsigned CNT_W = 32
);
  import core_pkg::*;

  logic                run;
  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic                mem_ready;
  logic                pc_write;
  logic                pc_src;
  logic                ir_write;
  logic                reg_write_enable;
  logic                data_mem_read_enable;
  logic                data_mem_write_enable;
  logic                mem_to_reg_sel;
  logic                alu_source_sel;
  logic [ALU_OP_W-1:0] alu_op;
  logic [STATE_W-1:0]  state_o;
  logic                halted;
  logic                fault;
  logic [CNT_W-1:0]    retired;

  modport master (
    input  run, opcode, zero, mem_ready,
    output pc_write, pc_src, ir_write, reg_write_enable, data_mem_read_enable,
           data_mem_write_enable, mem_to_reg_sel, alu_source_sel, alu_op,
           state_o, halted, fault, retired
  );

  modport slave (
    output run, opcode, zero, mem_ready,
    input  pc_write, pc_src, ir_write, reg_write_enable, data_mem_read_enable,
           data_mem_write_enable, mem_to_reg_sel, alu_source_sel, alu_op,
           state_o, halted, fault, retired
  );
endinterface

// File: rtl/core_opcode_decode.sv
// Combinational opcode classifier; anything unrecognised is flagged illegal.
module core_opcode_decode
  import core_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output instr_class_t        cls,
  output logic                illegal
);

  // Map the 7-bit major opcode onto an instruction class.
  always_comb begin
    cls     = CLS_NONE;
    illegal = 1'b0;
    case (opcode)
      OPC_R:     cls = CLS_R;
      OPC_I:     cls = CLS_I;
      OPC_LOAD:  cls = CLS_LOAD;
      OPC_STORE: cls = CLS_STORE;
      OPC_BEQ:   cls = CLS_BEQ;
      OPC_SYS:   cls = CLS_SYS;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the RV32I-subset core: one instruction at a time,
// memory-ready handshake with timeout, retire counter and sticky halt/fault.
module core_sequencer
  import core_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  core_sequencer_if.master  bus
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state;
  state_t            state_nxt;
  instr_class_t      cls_q;
  instr_class_t      cls_dec;
  logic              illegal;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  retired;
  logic              fault_q;
  logic              retire_c;
  logic              fault_set_c;

  core_opcode_decode u_decode (
    .opcode  (bus.opcode),
    .cls     (cls_dec),
    .illegal (illegal)
  );

  // Next-state, retire and fault-cause decisions.
  always_comb begin
    state_nxt   = state;
    retire_c    = 1'b0;
    fault_set_c = 1'b0;
    case (state)
      ST_IDLE:   if (bus.run) state_nxt = ST_FETCH;
      ST_FETCH:  state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (illegal) begin
          state_nxt   = ST_HALT;
          fault_set_c = 1'b1;
        end else if (cls_dec == CLS_SYS) begin
          state_nxt = ST_HALT;
        end else begin
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_R, CLS_I:         state_nxt = ST_WB;
          CLS_LOAD, CLS_STORE:  state_nxt = ST_MEM;
          CLS_BEQ:              retire_c  = 1'b1;
          default: begin
            state_nxt   = ST_HALT;
            fault_set_c = 1'b1;
          end
        endcase
      end
      ST_MEM: begin
        if (bus.mem_ready) begin
          if (cls_q == CLS_LOAD) state_nxt = ST_WB;
          else                   retire_c  = 1'b1;
        end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
          state_nxt   = ST_HALT;
          fault_set_c = 1'b1;
        end
      end
      ST_WB:   retire_c  = 1'b1;
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_HALT;
    endcase
    // run is only consulted at an instruction boundary
    if (retire_c) state_nxt = bus.run ? ST_FETCH : ST_IDLE;
  end

  // Datapath controls decoded from state and latched class; they fall with rst.
  always_comb begin
    bus.pc_write              = 1'b0;
    bus.pc_src                = 1'b0;
    bus.ir_write              = 1'b0;
    bus.reg_write_enable      = 1'b0;
    bus.data_mem_read_enable  = 1'b0;
    bus.data_mem_write_enable = 1'b0;
    bus.mem_to_reg_sel        = 1'b0;
    bus.alu_source_sel        = 1'b0;
    bus.alu_op                = ALU_OP_ADD;
    case (state)
      ST_FETCH: bus.ir_write = 1'b1;
      ST_EXEC: begin
        case (cls_q)
          CLS_R: bus.alu_op = ALU_OP_FUNCT;
          CLS_I: begin
            bus.alu_op         = ALU_OP_FUNCT;
            bus.alu_source_sel = 1'b1;
          end
          CLS_LOAD, CLS_STORE: bus.alu_source_sel = 1'b1;
          CLS_BEQ: begin
            bus.alu_op   = ALU_OP_SUB;
            bus.pc_write = 1'b1;
            bus.pc_src   = bus.zero;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        bus.alu_source_sel        = 1'b1;
        bus.data_mem_read_enable  = (cls_q == CLS_LOAD);
        bus.data_mem_write_enable = (cls_q == CLS_STORE);
        bus.pc_write              = (cls_q == CLS_STORE) && bus.mem_ready;
      end
      ST_WB: begin
        bus.reg_write_enable = 1'b1;
        bus.mem_to_reg_sel   = (cls_q == CLS_LOAD);
        bus.pc_write         = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.state_o = state;
  assign bus.halted  = (state == ST_HALT);
  assign bus.fault   = fault_q;
  assign bus.retired = retired;

  // State, latched class, MEM wait counter, retire counter and sticky fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cls_q    <= CLS_NONE;
      wait_cnt <= '0;
      retired  <= '0;
      fault_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_DECODE) cls_q <= cls_dec;
      if (state == ST_EXEC)      wait_cnt <= '0;
      else if (state == ST_MEM)  wait_cnt <= wait_cnt + WAIT_W'(1);
      if (retire_c)    retired <= retired + CNT_W'(1);
      if (fault_set_c) fault_q <= 1'b1;
    end
  end

endmodule
